// File: rtl/discr_scaler_ctrl.sv
// Gate-window controller for the discriminator scaler: schedules the inhibit length,
// counts accepted rising edges per window and hands results over a valid/ack pair.
// Optional running total enabled by defining DISCR_SCALER_TOTAL_EN.
module discr_scaler_ctrl #(
  parameter int P_N_WIDTH      = 32,
  parameter int P_PERIOD_WIDTH = 32,
  parameter int P_CNT_WIDTH    = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef DISCR_SCALER_TOTAL_EN
  input  logic                      total_clr,
  output logic [47:0]               total_cnt,
`endif
  input  logic                      cfg_en,
  input  logic                      cfg_wr,
  input  logic [P_PERIOD_WIDTH-1:0] cfg_period,
  input  logic [P_N_WIDTH-1:0]      cfg_inhibit_len,
  output logic                      cfg_pending,
  output logic [P_N_WIDTH-1:0]      inhibit_len,
  input  logic [7:0]                gen_bits,
  input  logic [7:0]                gen_inhibit,
  output logic                      busy,
  output logic [P_CNT_WIDTH-1:0]    cnt_out,
  output logic                      cnt_valid,
  output logic                      cnt_sat,
  output logic                      cnt_overrun,
  input  logic                      rd_ack
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                settle_q, settle_d;
  logic [P_PERIOD_WIDTH-1:0] win_q, win_d, per_q, per_d, pper_q, pper_d;
  logic [P_N_WIDTH-1:0]      inh_q, inh_d, pinh_q, pinh_d;
  logic                      pend_q, pend_d;
  logic                      prev7_q, prev7_d;
  logic [P_CNT_WIDTH-1:0]    acc_q, acc_d, cnt_out_q, cnt_out_d;
  logic                      sat_q, sat_d;
  logic                      cnt_valid_q, cnt_valid_d;
  logic                      cnt_sat_q, cnt_sat_d;
  logic                      cnt_overrun_q, cnt_overrun_d;

  logic [7:0]                acc_bits;
  logic [3:0]                pop;
  logic [P_CNT_WIDTH+3:0]    sum_ext;
  logic                      sum_ovf;
  logic [P_CNT_WIDTH-1:0]    sum_sat;
  logic                      win_end;
  logic                      apply;

  // Bit i is an edge when it is high and the sample just before it (bit i-1,
  // or last cycle's bit 7 for bit 0) was low.
  assign acc_bits = gen_bits & ~{gen_bits[6:0], prev7_q} & ~gen_inhibit;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) pop = pop + 4'(acc_bits[i]);
  end

  assign sum_ext = (P_CNT_WIDTH+4)'(acc_q) + (P_CNT_WIDTH+4)'(pop);
  assign sum_ovf = |sum_ext[P_CNT_WIDTH+3:P_CNT_WIDTH];
  assign sum_sat = sum_ovf ? '1 : sum_ext[P_CNT_WIDTH-1:0];

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d       = state_q;
    settle_d      = settle_q;
    win_d         = win_q;
    per_d         = per_q;
    pper_d        = pper_q;
    inh_d         = inh_q;
    pinh_d        = pinh_q;
    pend_d        = pend_q;
    prev7_d       = gen_bits[7];
    acc_d         = acc_q;
    sat_d         = sat_q;
    cnt_out_d     = cnt_out_q;
    cnt_valid_d   = cnt_valid_q;
    cnt_sat_d     = cnt_sat_q;
    cnt_overrun_d = cnt_overrun_q;
    win_end       = 1'b0;
    apply         = 1'b0;

    if (rd_ack && cnt_valid_q) begin
      cnt_valid_d   = 1'b0;
      cnt_overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        sat_d = 1'b0;
        apply = pend_q;
        if (cfg_en && ((pend_q ? pper_q : per_q) != '0)) begin
          state_d  = S_SETTLE;
          settle_d = 2'd2;
        end
      end
      S_SETTLE: begin
        if (!cfg_en) begin
          state_d = S_IDLE;
        end else if (settle_q == 2'd0) begin
          state_d = S_COUNT;
          acc_d   = '0;
          sat_d   = 1'b0;
          win_d   = per_q - P_PERIOD_WIDTH'(1);
        end else begin
          settle_d = settle_q - 2'd1;
        end
      end
      S_COUNT: begin
        if (!cfg_en) begin
          state_d = S_IDLE;
        end else if (win_q == '0) begin
          win_end = 1'b1;
          acc_d   = '0;
          sat_d   = 1'b0;
          if (pend_q) begin
            apply = 1'b1;
            if (pper_q != '0) begin
              state_d  = S_SETTLE;
              settle_d = 2'd2;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            win_d = per_q - P_PERIOD_WIDTH'(1);
          end
        end else begin
          win_d = win_q - P_PERIOD_WIDTH'(1);
          acc_d = sum_sat;
          sat_d = sat_q | sum_ovf;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A read acknowledged in the same cycle as a window end retires the old
    // result, so the new one is not an overrun.
    if (win_end) begin
      cnt_out_d     = sum_sat;
      cnt_sat_d     = sat_q | sum_ovf;
      cnt_valid_d   = 1'b1;
      cnt_overrun_d = rd_ack ? 1'b0 : (cnt_overrun_q | cnt_valid_q);
    end

    if (apply) begin
      per_d  = pper_q;
      inh_d  = pinh_q;
      pend_d = 1'b0;
    end

    if (cfg_wr) begin
      pend_d = 1'b1;
      pper_d = cfg_period;
      pinh_d = cfg_inhibit_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      settle_q      <= '0;
      win_q         <= '0;
      per_q         <= '0;
      pper_q        <= '0;
      inh_q         <= '0;
      pinh_q        <= '0;
      pend_q        <= 1'b0;
      prev7_q       <= 1'b0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      cnt_out_q     <= '0;
      cnt_valid_q   <= 1'b0;
      cnt_sat_q     <= 1'b0;
      cnt_overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      settle_q      <= settle_d;
      win_q         <= win_d;
      per_q         <= per_d;
      pper_q        <= pper_d;
      inh_q         <= inh_d;
      pinh_q        <= pinh_d;
      pend_q        <= pend_d;
      prev7_q       <= prev7_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      cnt_out_q     <= cnt_out_d;
      cnt_valid_q   <= cnt_valid_d;
      cnt_sat_q     <= cnt_sat_d;
      cnt_overrun_q <= cnt_overrun_d;
    end
  end

`ifdef DISCR_SCALER_TOTAL_EN
  logic [47:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (total_clr)    total_d = win_end ? 48'(cnt_out_d) : '0;
    else if (win_end) total_d = total_q + 48'(cnt_out_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) total_q <= '0;
    else        total_q <= total_d;
  end

  assign total_cnt = total_q;
`endif

  assign cfg_pending = pend_q;
  assign inhibit_len = inh_q;
  assign busy        = (state_q != S_IDLE);
  assign cnt_out     = cnt_out_q;
  assign cnt_valid   = cnt_valid_q;
  assign cnt_sat     = cnt_sat_q;
  assign cnt_overrun = cnt_overrun_q;

endmodule

// File: tb/tb_discr_scaler_ctrl.sv
// Directed bench for discr_scaler_ctrl: a default-width instance plus a 4-bit
// counter instance sharing the same stimulus for the saturation/overrun cases.
module tb_discr_scaler_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en, cfg_wr, rd_ack;
  logic [31:0] cfg_period, cfg_inhibit_len;
  logic [7:0]  gen_bits, gen_inhibit;

  logic        cfg_pending, busy, cnt_valid, cnt_sat, cnt_overrun;
  logic [31:0] inhibit_len;
  logic [23:0] cnt_out;

  logic        s_cfg_pending, s_busy, s_cnt_valid, s_cnt_sat, s_cnt_overrun;
  logic [31:0] s_inhibit_len;
  logic [3:0]  s_cnt_out;

`ifdef DISCR_SCALER_TOTAL_EN
  logic        total_clr = 1'b0;
  logic [47:0] total_cnt, s_total_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic       alt_en = 1'b0;
  logic       alt_ph = 1'b0;
  logic [7:0] pat_a, pat_b;

  always #5 clk = ~clk;

  discr_scaler_ctrl dut (
    .clk(clk), .rst_n(rst_n),
`ifdef DISCR_SCALER_TOTAL_EN
    .total_clr(total_clr), .total_cnt(total_cnt),
`endif
    .cfg_en(cfg_en), .cfg_wr(cfg_wr), .cfg_period(cfg_period),
    .cfg_inhibit_len(cfg_inhibit_len), .cfg_pending(cfg_pending),
    .inhibit_len(inhibit_len), .gen_bits(gen_bits), .gen_inhibit(gen_inhibit),
    .busy(busy), .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_sat(cnt_sat),
    .cnt_overrun(cnt_overrun), .rd_ack(rd_ack)
  );

  discr_scaler_ctrl #(.P_CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
`ifdef DISCR_SCALER_TOTAL_EN
    .total_clr(total_clr), .total_cnt(s_total_cnt),
`endif
    .cfg_en(cfg_en), .cfg_wr(cfg_wr), .cfg_period(cfg_period),
    .cfg_inhibit_len(cfg_inhibit_len), .cfg_pending(s_cfg_pending),
    .inhibit_len(s_inhibit_len), .gen_bits(gen_bits), .gen_inhibit(gen_inhibit),
    .busy(s_busy), .cnt_out(s_cnt_out), .cnt_valid(s_cnt_valid), .cnt_sat(s_cnt_sat),
    .cnt_overrun(s_cnt_overrun), .rd_ack(rd_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the rising edge, outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
    if (alt_en) begin
      alt_ph   = ~alt_ph;
      gen_bits = alt_ph ? pat_b : pat_a;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input bit sel, input int budget, output int n);
    n = 0;
    while (((sel ? s_cnt_valid : cnt_valid) !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    check(tag, sel ? s_cnt_valid : cnt_valid, 1'b1);
  endtask

  task automatic wait_applied(input string tag, input int budget);
    int n = 0;
    while (cfg_pending === 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, cfg_pending, 1'b0);
  endtask

  initial begin
    int  n;
    logic inh_early;
    logic seen;

    rst_n = 1'b0; cfg_en = 1'b0; cfg_wr = 1'b0; rd_ack = 1'b0;
    cfg_period = '0; cfg_inhibit_len = '0; gen_bits = '0; gen_inhibit = '0;
    pat_a = 8'h55; pat_b = 8'h00;
    #3;
    check("rst_valid", cnt_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt_out", cnt_out, 24'd0);
    steps(2);
    rst_n = 1'b1;
    step();

    // Constant 8'h01: one edge per cycle, 100-cycle windows.
    cfg_period = 100; cfg_inhibit_len = 0; gen_bits = 8'h01; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    check("pending_set", cfg_pending, 1'b1);
    check("idle_not_busy", busy, 1'b0);
    step();
    check("idle_apply_clears_pending", cfg_pending, 1'b0);
    cfg_en = 1'b1;
    step();
    check("busy_after_en", busy, 1'b1);
    wait_valid("first_window_timeout", 1'b0, 300, n);
    check("first_window_latency", n + 1, 104);
    check("w100_cnt", cnt_out, 24'd100);
    check("w100_sat", cnt_sat, 1'b0);
    check("w100_overrun", cnt_overrun, 1'b0);
    ack();
    check("ack_clears_valid", cnt_valid, 1'b0);
    wait_valid("w100_second_timeout", 1'b0, 300, n);
    check("w100_no_gap_period", n + 1, 100);
    check("w100_second_cnt", cnt_out, 24'd100);

    // Alternating 55/00 over 4-cycle windows, applied at the running window's end.
    cfg_period = 4; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    alt_en = 1'b1;
    wait_applied("p4_apply_timeout", 300);
    ack();
    wait_valid("p4_w1_timeout", 1'b0, 50, n);
    check("alt55_00_cnt", cnt_out, 24'd8);
    ack();
    wait_valid("p4_w2_timeout", 1'b0, 50, n);
    check("p4_period", n + 1, 4);
    check("alt55_00_cnt2", cnt_out, 24'd8);

    // 55/AA: AA after 55 gives 4 edges, 55 after AA gives 3 (bit 0 blocked by prev bit 7).
    pat_b = 8'hAA;
    ack();
    wait_valid("aa_w1_timeout", 1'b0, 50, n);
    ack();
    wait_valid("aa_w2_timeout", 1'b0, 50, n);
    check("alt55_aa_cnt", cnt_out, 24'd14);

    // Inhibit masks the bit-4 edge of 8'h11.
    alt_en = 1'b0; gen_bits = 8'h11; gen_inhibit = 8'hFE;
    ack();
    wait_valid("inh_w1_timeout", 1'b0, 50, n);
    ack();
    wait_valid("inh_w2_timeout", 1'b0, 50, n);
    check("inhibit_mask_cnt", cnt_out, 24'd4);

    // Mid-window reconfiguration: inhibit_len holds until the window end.
    cfg_period = 10; cfg_inhibit_len = 20; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    check("midwin_pending", cfg_pending, 1'b1);
    check("midwin_inh_hold", inhibit_len, 32'd0);
    inh_early = 1'b0;
    n = 0;
    while (cfg_pending === 1'b1 && n < 50) begin
      if (inhibit_len !== 32'd0) inh_early = 1'b1;
      step();
      n++;
    end
    check("midwin_inh_early", inh_early, 1'b0);
    check("midwin_applied", cfg_pending, 1'b0);
    check("midwin_inh_new", inhibit_len, 32'd20);
    check("midwin_old_result", cnt_out, 24'd4);
    check("midwin_settle_busy", busy, 1'b1);
    ack();
    wait_valid("p10_timeout", 1'b0, 50, n);
    check("settle_plus_window", n + 1, 13);
    check("p10_cnt", cnt_out, 24'd10);

    // Dropping cfg_en mid-window discards the partial count.
    ack();
    steps(3);
    cfg_en = 1'b0;
    step();
    check("en_drop_idle", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cnt_valid !== 1'b0) seen = 1'b1;
    end
    check("en_drop_no_result", seen, 1'b0);

    // 4-bit counter: four edges/cycle over 4 cycles saturates at 15.
    gen_bits = 8'h55; gen_inhibit = 8'h00;
    cfg_period = 4; cfg_inhibit_len = 0; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    ack();
    check("s_pre_valid", s_cnt_valid, 1'b0);
    check("s_pre_overrun", s_cnt_overrun, 1'b0);
    cfg_en = 1'b1;
    wait_valid("s_w1_timeout", 1'b1, 50, n);
    check("s_sat_cnt", s_cnt_out, 4'd15);
    check("s_sat_flag", s_cnt_sat, 1'b1);
    check("s_no_overrun_yet", s_cnt_overrun, 1'b0);
    check("wide_cnt", cnt_out, 24'd16);
    check("wide_no_sat", cnt_sat, 1'b0);
    steps(4);
    check("s_overrun_set", s_cnt_overrun, 1'b1);
    steps(3);
    check("s_overrun_sticky", s_cnt_overrun, 1'b1);
    ack();
    check("s_ack_at_end_valid", s_cnt_valid, 1'b1);
    check("s_ack_at_end_overrun", s_cnt_overrun, 1'b0);
    ack();
    check("s_ack_clears_valid", s_cnt_valid, 1'b0);

    // Reset while counting with a non-zero inhibit length applied.
    cfg_period = 5; cfg_inhibit_len = 7; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    wait_applied("inh7_apply_timeout", 50);
    check("inh7_applied", inhibit_len, 32'd7);
    steps(6);
    rst_n = 1'b0;
    #2;
    check("midrst_busy", busy, 1'b0);
    check("midrst_inh", inhibit_len, 32'd0);
    check("midrst_valid", cnt_valid, 1'b0);
    check("midrst_cnt", cnt_out, 24'd0);
    check("midrst_sat", cnt_sat, 1'b0);
    check("midrst_overrun", cnt_overrun, 1'b0);
    check("midrst_pending", cfg_pending, 1'b0);
    step();
    rst_n = 1'b1;
    steps(3);
    check("post_rst_idle_per0", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
